// File: rtl/q2_panel_seq.sv
// Front-panel sequencer for the q2 core: synchronises and debounces the console
// buttons and turns each accepted press into fixed-width strobes, with auto-increment and single step.
module q2_panel_seq #(
    parameter int DEB_BITS     = 16,
    parameter int PULSE_CYCLES = 4,
    parameter int STEP_CYCLES  = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_dep,
    input  logic btn_incp,
    input  logic btn_start,
    input  logic btn_stop,
    input  logic btn_step,
    input  logic autoinc,
    input  logic run,
    output logic dep_sw,
    output logic incp_sw,
    output logic start_sw,
    output logic stop_sw,
    output logic busy
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_STROBE    = 2'd1;
    localparam logic [1:0] S_GAP       = 2'd2;
    localparam logic [1:0] S_STEP_WAIT = 2'd3;

    localparam logic [1:0] SEL_DEP   = 2'd0;
    localparam logic [1:0] SEL_INCP  = 2'd1;
    localparam logic [1:0] SEL_START = 2'd2;
    localparam logic [1:0] SEL_STOP  = 2'd3;

    // Button bit positions inside the 5-bit vectors.
    localparam int B_DEP   = 0;
    localparam int B_INCP  = 1;
    localparam int B_START = 2;
    localparam int B_STOP  = 3;
    localparam int B_STEP  = 4;

    localparam int CNT_MAX = (PULSE_CYCLES > STEP_CYCLES) ? PULSE_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
        case (sel)
            SEL_DEP:   return 4'b0001;
            SEL_INCP:  return 4'b0010;
            SEL_START: return 4'b0100;
            SEL_STOP:  return 4'b1000;
            default:   return 4'b0000;
        endcase
    endfunction

    logic [5:0]          raw_s;
    logic [5:0]          sync1_q;
    logic [5:0]          sync2_q;
    logic                run_s;
    logic [4:0]          deb_lvl_q;
    logic [4:0]          deb_lvl_d;
    logic [DEB_BITS-1:0] deb_cnt_q [0:4];
    logic [DEB_BITS-1:0] deb_cnt_d [0:4];
    logic [4:0]          press_s;
    logic [4:0]          accept_s;
    logic [4:0]          pend_q;
    logic [4:0]          pend_d;
    logic [4:0]          pend_clr_s;

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [1:0]          sel_q;
    logic [1:0]          sel_d;
    logic                step_q;
    logic                step_d;
    logic                ainc_q;
    logic                ainc_d;
    logic [3:0]          strb_q;
    logic [3:0]          strb_d;
    logic                busy_q;
    logic                busy_d;

    assign raw_s = {run, btn_step, btn_stop, btn_start, btn_incp, btn_dep};
    assign run_s = sync2_q[5];

    // Debounce: a level is only accepted after the counter saturates; a rising acceptance is a press.
    always_comb begin
        deb_lvl_d = deb_lvl_q;
        press_s   = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] == deb_lvl_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == {DEB_BITS{1'b1}}) begin
                deb_cnt_d[i] = '0;
                deb_lvl_d[i] = sync2_q[i];
                press_s[i]   = sync2_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DEB_BITS'(1);
            end
        end
    end

    // While the core runs only stop presses are latched; a new press wins over a same-cycle clear.
    always_comb begin
        accept_s = press_s & {~run_s, 1'b1, ~run_s, ~run_s, ~run_s};
        pend_d   = (pend_q & ~pend_clr_s) | accept_s;
    end

    // Input synchronisers, debounce state and pending flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 6'b000000;
            sync2_q   <= 6'b000000;
            deb_lvl_q <= 5'b00000;
            pend_q    <= 5'b00000;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= raw_s;
            sync2_q   <= sync1_q;
            deb_lvl_q <= deb_lvl_d;
            pend_q    <= pend_d;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // Sequencer next-state logic; the counter restarts from zero on every state entry.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        step_d     = step_q;
        ainc_d     = ainc_q;
        pend_clr_s = 5'b00000;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (pend_q[B_STOP]) begin
                    pend_clr_s[B_STOP] = 1'b1;
                    sel_d   = SEL_STOP;
                    step_d  = 1'b0;
                    ainc_d  = 1'b0;
                    state_d = S_STROBE;
                end else if (pend_q[B_START]) begin
                    pend_clr_s[B_START] = 1'b1;
                    sel_d   = SEL_START;
                    step_d  = 1'b0;
                    ainc_d  = 1'b0;
                    state_d = S_STROBE;
                end else if (pend_q[B_STEP]) begin
                    pend_clr_s[B_STEP] = 1'b1;
                    sel_d   = SEL_START;
                    step_d  = 1'b1;
                    ainc_d  = 1'b0;
                    state_d = S_STROBE;
                end else if (pend_q[B_DEP]) begin
                    pend_clr_s[B_DEP] = 1'b1;
                    sel_d   = SEL_DEP;
                    step_d  = 1'b0;
                    ainc_d  = autoinc;
                    state_d = S_STROBE;
                end else if (pend_q[B_INCP]) begin
                    pend_clr_s[B_INCP] = 1'b1;
                    sel_d   = SEL_INCP;
                    step_d  = 1'b0;
                    ainc_d  = 1'b0;
                    state_d = S_STROBE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STROBE: begin
                if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                    cnt_d = '0;
                    if ((sel_q == SEL_DEP) && ainc_q) begin
                        sel_d   = SEL_INCP;
                        ainc_d  = 1'b0;
                        state_d = S_STROBE;
                    end else if (step_q && (sel_q == SEL_START)) begin
                        state_d = S_STEP_WAIT;
                    end else begin
                        step_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STEP_WAIT: begin
                // A stop press consumes the flag here so only one stop strobe goes out.
                if (pend_q[B_STOP]) begin
                    pend_clr_s[B_STOP] = 1'b1;
                    cnt_d   = '0;
                    sel_d   = SEL_STOP;
                    state_d = S_STROBE;
                end else if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    sel_d   = SEL_STOP;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                step_d  = 1'b0;
                ainc_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes and busy are decoded from the next state so the pins come straight off flops.
    always_comb begin
        if (state_d == S_STROBE) begin
            strb_d = sel_onehot(sel_d);
        end else begin
            strb_d = 4'b0000;
        end
        busy_d = (state_d != S_IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= SEL_DEP;
            step_q  <= 1'b0;
            ainc_q  <= 1'b0;
            strb_q  <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            step_q  <= step_d;
            ainc_q  <= ainc_d;
            strb_q  <= strb_d;
            busy_q  <= busy_d;
        end
    end

    assign dep_sw   = strb_q[0];
    assign incp_sw  = strb_q[1];
    assign start_sw = strb_q[2];
    assign stop_sw  = strb_q[3];
    assign busy     = busy_q;

endmodule
